// File: rtl/cpu_pkg.sv
// Shared definitions for the branch sequencer: opcode default, condition codes
// and FSM state encoding.
package cpu_pkg;

  localparam logic [4:0] BR_OPCODE_DEF = 5'b10011;

  typedef enum logic [1:0] {
    BRZR = 2'b00,
    BRNZ = 2'b01,
    BRPL = 2'b10,
    BRMI = 2'b11
  } condT;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EVAL   = 3'd1,
    DECIDE = 3'd2,
    LOAD   = 3'd3,
    DONE   = 3'd4
  } stateT;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: tests the condition register value
// against the selected c2 condition.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [31:0] busVal,
  input  condT        c2,
  output logic        condMet
);

  always_comb begin
    condMet = 1'b0;
    unique case (c2)
      BRZR: condMet = (busVal == 32'd0);
      BRNZ: condMet = (busVal != 32'd0);
      BRPL: condMet = !busVal[31] && (busVal != 32'd0);
      BRMI: condMet = busVal[31];
    endcase
  end

endmodule

// File: rtl/branch_seq.sv
// Conditional-branch control sequencer: evaluates the condition register,
// loads the PC from the target register when taken, counts taken branches.
module branch_seq
  import cpu_pkg::*;
#(
  parameter logic [4:0] BR_OPCODE = BR_OPCODE_DEF,
  parameter int         CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic [31:0]      bus_in,
  output logic             ra_out,
  output logic             rb_out,
  output logic             pc_in,
  output logic             con_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] taken_cnt
);

  stateT state;
  condT  c2Held;
  logic  condMet;
  logic  unusedIr;

  assign unusedIr = ^{ir[26:21], ir[18:0]};

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  cond_eval uCondEval (
    .busVal (bus_in),
    .c2     (c2Held),
    .condMet(condMet)
  );

  // Strobes are registered alongside the state transition that enters the
  // state they belong to, so they are glitch-free and Moore in effect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      c2Held    <= BRZR;
      con_out   <= 1'b0;
      taken_cnt <= '0;
      ra_out    <= 1'b0;
      rb_out    <= 1'b0;
      pc_in     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ra_out <= 1'b0;
      rb_out <= 1'b0;
      pc_in  <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start && ir[31:27] == BR_OPCODE) begin
            c2Held <= condT'(ir[20:19]);
            state  <= EVAL;
            ra_out <= 1'b1;
            busy   <= 1'b1;
          end
        end
        EVAL: begin
          con_out <= condMet;
          state   <= DECIDE;
        end
        DECIDE: begin
          if (con_out) begin
            state  <= LOAD;
            rb_out <= 1'b1;
            pc_in  <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        LOAD: begin
          taken_cnt <= satInc(taken_cnt);
          state     <= DONE;
          done      <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 Parameter: BR_OPCODE, default 5'b10011, opcode value IR[31:27] that identifies a conditional branch.
REQ-002 Parameter: CNT_W, default 16, width of taken-branch statistics counter.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to execute the instruction held on ir.
REQ-006 ir  input  32  instruction register; opcode IR[31:27], condition field c2 = IR[20:19].
REQ-007 bus_in  input  32  datapath bus value, valid during EVAL (condition register contents).
REQ-008 ra_out  output  1  strobe: drive condition register onto bus.
REQ-009 rb_out  output  1  strobe: drive branch-target register onto bus.
REQ-010 pc_in  output  1  strobe: load PC from bus this cycle.
REQ-011 con_out  output  1  registered condition result of last evaluated branch.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 taken_cnt  output  CNT_W  count of branches taken since reset.

Function
REQ-015 FSM states SHALL be IDLE, EVAL, DECIDE, LOAD, DONE; strobes decoded from state only (Moore).
REQ-016 IDLE: start=1 and IR[31:27]==BR_OPCODE -> EVAL; start with any other opcode SHALL be ignored (stay IDLE, no strobes).
REQ-017 The c2 field SHALL be captured on the start-accept edge and held for the whole operation; later ir changes have no effect.
REQ-018 EVAL: ra_out=1 for exactly one cycle; on the EVAL->DECIDE edge con_out SHALL load cond(c2, bus_in).
REQ-019 cond: 00 brzr -> bus_in==0; 01 brnz -> bus_in!=0; 10 brpl -> bus_in[31]==0 and bus_in!=0; 11 brmi -> bus_in[31]==1.
REQ-020 DECIDE: no strobes; con_out=1 -> LOAD, else -> DONE.
REQ-021 LOAD: rb_out=1 and pc_in=1 together for exactly one cycle; taken_cnt increments on this edge; -> DONE.
REQ-022 taken_cnt SHALL saturate at all-ones, never wrap.
REQ-023 DONE: done=1 for one cycle; -> IDLE unconditionally.
REQ-024 Latency: start-accept to done = 3 cycles not taken, 4 cycles taken.
REQ-025 start asserted while busy=1 SHALL be ignored and not queued.
REQ-026 ra_out, rb_out, pc_in SHALL never be asserted outside EVAL/LOAD; ra_out and rb_out never asserted together.
REQ-027 con_out SHALL hold its value between operations and update only in EVAL->DECIDE.

Reset
REQ-028 reset=1 SHALL asynchronously force state IDLE, con_out=0, taken_cnt=0, captured c2=0.
REQ-029 All outputs (ra_out, rb_out, pc_in, busy, done) SHALL read 0 while reset is high.
REQ-030 Reset mid-operation (any state) SHALL abort with no pc_in or done pulse; first start after release is accepted normally.

Structure
REQ-031 BR_OPCODE default, c2 encodings (BRZR/BRNZ/BRPL/BRMI) and FSM state encoding SHALL live in the shared package cpu_pkg.
REQ-032 Condition evaluation SHALL be a separate combinational sub-module cond_eval (inputs bus value and c2, output one bit), instantiated once.

Verification
REQ-033 brzr, bus_in=0x00000000 -> ra_out cycle 1, con_out=1, rb_out+pc_in cycle 3, done cycle 4, taken_cnt=1.
REQ-034 brpl, bus_in=0x00000000 and brmi, bus_in=0x80000000 -> first not taken (done cycle 3, no pc_in), second taken; brpl with 0x80000000 not taken.
REQ-035 start with IR[31:27]=5'b00001 -> stays IDLE, busy=0, no strobes, con_out unchanged.
REQ-036 second start pulse during DECIDE, ir changed to c2=01 -> ignored; original c2 result used, exactly one done.
REQ-037 reset asserted in LOAD-preceding DECIDE cycle (taken case) -> no pc_in, no done, taken_cnt=0, con_out=0 immediately.
REQ-038 CNT_W=4, 17 taken branches -> taken_cnt=4'hF after 15th and stays 4'hF.
